// File: rtl/intrude_pkg.sv
// Shared types and constants for the memory-cycle intrusion arbiter.
package intrude_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ADDR   = 2'd1,
    ST_STROBE = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  localparam logic [1:0] OWN_NONE = 2'd0;
  localparam logic [1:0] OWN_DSP  = 2'd1;
  localparam logic [1:0] OWN_BLT  = 2'd2;
  localparam logic [1:0] OWN_CPU  = 2'd3;

  localparam int TIMEOUT_DEF = 15;

endpackage

// File: rtl/intrude_rr3.sv
// Three-way rotating-priority picker; the last granted requester drops to lowest priority.
module intrude_rr3
  import intrude_pkg::*;
(
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic [2:0] i_req,
  input  logic       i_take,
  output logic [1:0] o_owner
);

  logic [1:0] r_last;

  // Search order starts just after the previous winner: {DSP, BLT, CPU} = i_req[0..2]
  always_comb begin
    o_owner = OWN_NONE;
    case (r_last)
      OWN_DSP: begin
        if      (i_req[1]) o_owner = OWN_BLT;
        else if (i_req[2]) o_owner = OWN_CPU;
        else if (i_req[0]) o_owner = OWN_DSP;
      end
      OWN_BLT: begin
        if      (i_req[2]) o_owner = OWN_CPU;
        else if (i_req[0]) o_owner = OWN_DSP;
        else if (i_req[1]) o_owner = OWN_BLT;
      end
      default: begin
        if      (i_req[0]) o_owner = OWN_DSP;
        else if (i_req[1]) o_owner = OWN_BLT;
        else if (i_req[2]) o_owner = OWN_CPU;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_last <= OWN_CPU;
    end else if (i_take && (o_owner != OWN_NONE)) begin
      r_last <= o_owner;
    end
  end

endmodule

// File: rtl/intrude_arb.sv
// Arbiter granting DSP/BLT/CPU memory cycles; IDLE -> ADDR -> STROBE -> DONE with TRUDY wait and timeout.
module intrude_arb
  import intrude_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic       CLK,
  input  logic       RESETL,
  input  logic       DSP_REQ,
  input  logic       BLT_REQ,
  input  logic       CPU_REQ,
  input  logic       DSP_RW,
  input  logic       BLT_RW,
  input  logic       CPU_RW,
  input  logic       TRUDY,
  output logic       RD,
  output logic       WR,
  output logic [1:0] GNT,
  output logic       DSP_ACK,
  output logic       BLT_ACK,
  output logic       CPU_ACK,
  output logic       ERR,
  output logic       BUSY
);

  localparam logic [3:0] LAST_WAIT = 4'(TIMEOUT - 1);

  state_t     r_state;
  logic [1:0] r_owner;
  logic       r_rw;
  logic [3:0] r_wait;
  logic       r_rd;
  logic       r_wr;
  logic [1:0] r_gnt;
  logic [2:0] r_ack;
  logic       r_err;
  logic       r_busy;

  logic [2:0] w_req;
  logic [1:0] w_pick;
  logic       w_pick_rw;
  logic       w_take;

  assign w_req  = {CPU_REQ, BLT_REQ, DSP_REQ};
  assign w_take = (r_state == ST_IDLE);

  intrude_rr3 u_rr3 (
    .i_clk   (CLK),
    .i_rst_n (RESETL),
    .i_req   (w_req),
    .i_take  (w_take),
    .o_owner (w_pick)
  );

  always_comb begin
    w_pick_rw = 1'b0;
    case (w_pick)
      OWN_DSP: w_pick_rw = DSP_RW;
      OWN_BLT: w_pick_rw = BLT_RW;
      OWN_CPU: w_pick_rw = CPU_RW;
      default: w_pick_rw = 1'b0;
    endcase
  end

  // Outputs are loaded together with the state they belong to, so each is a registered decode.
  always_ff @(posedge CLK or negedge RESETL) begin
    if (!RESETL) begin
      r_state <= ST_IDLE;
      r_owner <= OWN_NONE;
      r_rw    <= 1'b0;
      r_wait  <= 4'd0;
      r_rd    <= 1'b0;
      r_wr    <= 1'b0;
      r_gnt   <= OWN_NONE;
      r_ack   <= 3'b000;
      r_err   <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_ack <= 3'b000;
      r_err <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_pick != OWN_NONE) begin
            r_state <= ST_ADDR;
            r_owner <= w_pick;
            r_rw    <= w_pick_rw;
            r_gnt   <= w_pick;
            r_busy  <= 1'b1;
          end
        end
        ST_ADDR: begin
          r_state <= ST_STROBE;
          r_rd    <= r_rw;
          r_wr    <= ~r_rw;
        end
        ST_STROBE: begin
          if (!TRUDY) r_wait <= r_wait + 4'd1;
          // TRUDY wins over a simultaneous timeout
          if (TRUDY || (r_wait == LAST_WAIT)) begin
            r_state <= ST_DONE;
            r_rd    <= 1'b0;
            r_wr    <= 1'b0;
            r_ack   <= {r_owner == OWN_CPU, r_owner == OWN_BLT, r_owner == OWN_DSP};
            r_err   <= ~TRUDY;
          end
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
          r_gnt   <= OWN_NONE;
          r_busy  <= 1'b0;
          r_wait  <= 4'd0;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign RD      = r_rd;
  assign WR      = r_wr;
  assign GNT     = r_gnt;
  assign DSP_ACK = r_ack[0];
  assign BLT_ACK = r_ack[1];
  assign CPU_ACK = r_ack[2];
  assign ERR     = r_err;
  assign BUSY    = r_busy;

endmodule

// File: doc/intrude_arb.md
INTRUDE_ARB -- requirements
Module: intrude_arb

Interface
REQ-001 Parameter: TIMEOUT, default 15; maximum number of STROBE cycles spent waiting for TRUDY, range 1..15.
REQ-002 CLK  in  1  sole clock; all state updates on the rising edge.
REQ-003 RESETL  in  1  asynchronous, active-low reset.
REQ-004 DSP_REQ, BLT_REQ, CPU_REQ  in  1 each  memory-cycle requests; held high by the requester until it sees its ACK.
REQ-005 DSP_RW, BLT_RW, CPU_RW  in  1 each  direction per requester (1 = read, 0 = write); stable while the matching REQ is high.
REQ-006 TRUDY  in  1  memory ready; the cycle completes on the edge where TRUDY is sampled high.
REQ-007 RD, WR  out  1 each  registered strobes to the memory-cycle controller; never both high.
REQ-008 GNT  out  2  owner code: 0 = none, 1 = DSP, 2 = BLT, 3 = CPU.
REQ-009 DSP_ACK, BLT_ACK, CPU_ACK  out  1 each  one-cycle completion pulse to the owner.
REQ-010 ERR  out  1  one-cycle pulse, coincident with ACK, when the cycle was ended by timeout.
REQ-011 BUSY  out  1  high in every state except IDLE.

Function
REQ-012 FSM states: IDLE, ADDR, STROBE, DONE; all outputs are registered decodes of state plus owner.
REQ-013 IDLE: if any REQ is high, latch the winner and its RW bit, then go to ADDR; otherwise stay in IDLE.
REQ-014 Arbitration is rotating priority: the requester granted last gets lowest priority next time; the order after reset is DSP > BLT > CPU.
REQ-015 ADDR lasts exactly one cycle: GNT = owner, RD = WR = 0; next state is STROBE.
REQ-016 STROBE: RD = latched RW, WR = not latched RW; the 4-bit wait counter increments each cycle while TRUDY is low.
REQ-017 STROBE exit: TRUDY high, or wait counter = TIMEOUT-1 with TRUDY low, moves to DONE; TRUDY has priority when both occur in the same cycle.
REQ-018 DONE lasts one cycle: strobes low, GNT held, owner ACK = 1, ERR = 1 only on a timeout exit; next state is IDLE and the wait counter clears.
REQ-019 Minimum latency: REQ high in IDLE at cycle n gives ADDR at n+1, strobe at n+2 and, with TRUDY high at n+2, ACK at n+3 and IDLE at n+4.
REQ-020 A requester still high in the IDLE cycle after its ACK is treated as a new request, but it loses to any other pending requester.
REQ-021 Requests that drop before being granted are ignored; REQ and RW changes after the latch in IDLE have no effect on the current cycle.
REQ-022 GNT = 0 in IDLE; at most one ACK is high in any cycle.

Reset
REQ-023 RESETL low forces, without waiting for a clock edge: state IDLE, GNT = 0, RD = WR = 0, all ACK = 0, ERR = 0, BUSY = 0, wait counter = 0, priority pointer = DSP-first.
REQ-024 Reset asserted mid-cycle abandons the cycle: no ACK or ERR is issued for it.
REQ-025 After RESETL deasserts, the first edge evaluates the IDLE state normally.

Structure
REQ-026 A shared package holds the state enum, the GNT owner codes and the TIMEOUT default.
REQ-027 One sub-module, intrude_rr3, holds the 3-way rotating-priority picker and its pointer register; everything else lives in intrude_arb.

Verification
REQ-028 Single CPU read: CPU_REQ=1, CPU_RW=1, TRUDY high at the strobe -> GNT=3 at n+1, RD=1 at n+2, CPU_ACK at n+3, BUSY low at n+4.
REQ-029 All three requesting continuously from reset -> grant order DSP, BLT, CPU, DSP, ...; each ACK occurs exactly once per grant.
REQ-030 BLT write with TRUDY low for 3 strobe cycles -> WR high for 4 cycles, BLT_ACK on the next cycle, ERR=0.
REQ-031 TRUDY held low, TIMEOUT=15 -> WR or RD high for 15 cycles, then ACK with ERR=1, then IDLE.
REQ-032 TRUDY rises on the final timeout cycle -> ACK with ERR=0.
REQ-033 RESETL pulsed low during STROBE -> RD=WR=GNT=0 immediately, no ACK, and the next grant follows DSP-first order.
